// File: rtl/demux_2to4_l1_pkg.sv
// Shared definitions for the Rx Layer-1 2-to-4 de-interleaver.
// Holds the phase-tracker state encoding, the default lane width and idle
// limit, and the helper that sizes the idle counter.
package demux_2to4_l1_pkg;

    // Phase tracker states. UNSYNC means no lane alignment. EVEN and ODD
    // name the phase slot that the *current* cycle's stream bytes belong to.
    typedef enum logic [1:0] {
        ST_UNSYNC = 2'b00,
        ST_EVEN   = 2'b01,
        ST_ODD    = 2'b10
    } demuxState_t;

    // Default byte width of each recovered lane.
    localparam int DEFAULT_WIDTH = 8;

    // Default number of consecutive fully idle cycles before a locked
    // stream pair gives up its alignment.
    localparam int DEFAULT_IDLE_LIMIT = 4;

    // Width needed for an idle counter to hold the value 'limit' itself.
    // Guarded so that a degenerate limit still yields a 1-bit counter.
    function automatic int idleCountWidth(input int limit);
        int width;
        width = $clog2(limit + 1);
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/demux_2to4_l1_if.sv
// Bundle of the de-interleaver's stream inputs and recovered lane outputs.
// The master side is the upstream serial-to-parallel stage (it drives the
// two interleaved streams and observes the lanes); the slave side is the
// de-interleaver itself.
interface demux_2to4_l1_if
    import demux_2to4_l1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    // Interleaved input streams: stream 1 carries lanes 0/1, stream 2
    // carries lanes 2/3, alternating every clk_2f cycle.
    logic [WIDTH-1:0] data_in1;
    logic             valid_in1;
    logic [WIDTH-1:0] data_in2;
    logic             valid_in2;

    // Recovered lanes, each with its own qualifier.
    logic [WIDTH-1:0] data_out0;
    logic [WIDTH-1:0] data_out1;
    logic [WIDTH-1:0] data_out2;
    logic [WIDTH-1:0] data_out3;
    logic             valid_out0;
    logic             valid_out1;
    logic             valid_out2;
    logic             valid_out3;

    // High while the shared phase tracker is locked.
    logic             aligned;

    modport master (
        output data_in1,
        output valid_in1,
        output data_in2,
        output valid_in2,
        input  data_out0,
        input  data_out1,
        input  data_out2,
        input  data_out3,
        input  valid_out0,
        input  valid_out1,
        input  valid_out2,
        input  valid_out3,
        input  aligned
    );

    modport slave (
        input  data_in1,
        input  valid_in1,
        input  data_in2,
        input  valid_in2,
        output data_out0,
        output data_out1,
        output data_out2,
        output data_out3,
        output valid_out0,
        output valid_out1,
        output valid_out2,
        output valid_out3,
        output aligned
    );

endinterface

// File: rtl/demux_2to4_l1_demux_1to2_l1.sv
// Per-stream half of the de-interleaver. Captures the even-phase and
// odd-phase bytes of one interleaved stream into holding registers and,
// when told to, moves the completed pair to the output registers in one
// step. All phase decisions are made by the parent; this block only obeys
// the capture and load strobes it is given.
module demux_1to2_l1
    import demux_2to4_l1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    input  logic             i_captureEven,
    input  logic             i_captureOdd,
    input  logic             i_load,
    output logic [WIDTH-1:0] o_dataEven,
    output logic             o_validEven,
    output logic [WIDTH-1:0] o_dataOdd,
    output logic             o_validOdd
);

    // Holding pair. A byte that arrives without its valid is stored as zero
    // so that an unqualified lane can never leak stale bus contents.
    logic [WIDTH-1:0] r_evenData;
    logic             r_evenValid;
    logic [WIDTH-1:0] r_oddData;
    logic             r_oddValid;

    // Output registers, updated only on a load so both lanes of the pair
    // change together.
    logic [WIDTH-1:0] r_outEvenData;
    logic             r_outEvenValid;
    logic [WIDTH-1:0] r_outOddData;
    logic             r_outOddValid;

    // Masked view of the incoming byte, shared by both capture registers.
    logic [WIDTH-1:0] w_maskedData;

    assign w_maskedData = i_valid ? i_data : '0;

    // Even-phase holding register: the first byte of each lane pair.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_evenData  <= '0;
            r_evenValid <= 1'b0;
        end else if (i_captureEven) begin
            r_evenData  <= w_maskedData;
            r_evenValid <= i_valid;
        end
    end

    // Odd-phase holding register: the second byte of each lane pair.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_oddData  <= '0;
            r_oddValid <= 1'b0;
        end else if (i_captureOdd) begin
            r_oddData  <= w_maskedData;
            r_oddValid <= i_valid;
        end
    end

    // Output registers: present the completed pair, holding it until the
    // next load so downstream FIFOs see a steady half-rate word.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_outEvenData  <= '0;
            r_outEvenValid <= 1'b0;
            r_outOddData   <= '0;
            r_outOddValid  <= 1'b0;
        end else if (i_load) begin
            r_outEvenData  <= r_evenData;
            r_outEvenValid <= r_evenValid;
            r_outOddData   <= r_oddData;
            r_outOddValid  <= r_oddValid;
        end
    end

    assign o_dataEven  = r_outEvenData;
    assign o_validEven = r_outEvenValid;
    assign o_dataOdd   = r_outOddData;
    assign o_validOdd  = r_outOddValid;

endmodule

// File: rtl/demux_2to4_l1.sv
// Receive-side Layer-1 de-interleaver: the inverse of the Tx 4-to-2 mux.
// Two clk_2f streams, each alternating between two logical lanes, are split
// back into four byte lanes that update together once every two cycles.
// A single phase tracker serves both streams because the Tx side drives its
// two muxes from one clock and reset, so the streams are phase-locked.
module demux_2to4_l1
    import demux_2to4_l1_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int IDLE_LIMIT = DEFAULT_IDLE_LIMIT
) (
    input  logic           clk_2f,
    input  logic           reset,
    demux_2to4_l1_if.slave bus
);

    localparam int CW = idleCountWidth(IDLE_LIMIT);

    // Counter value that, followed by one more idle cycle, reaches the limit.
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_LIMIT - 1);

    // Largest value the counter may ever hold; it saturates here.
    localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_LIMIT);

    demuxState_t   r_state;
    logic [CW-1:0] r_idleCount;
    logic          r_loadPending;
    logic          r_aligned;

    logic          w_anyValid;
    logic          w_captureEven;
    logic          w_captureOdd;
    demuxState_t   w_nextPhase;

    // Strobes for the per-stream halves, decoded from the tracker state.
    // The very first valid cycle seen while unsynchronised is by definition
    // the even slot, so it captures like an EVEN cycle. The load strobe is
    // the registered "odd slot just captured" flag, which lets the output
    // registers pick up the odd byte after it has settled in its holding
    // register.
    always_comb begin
        w_anyValid    = bus.valid_in1 | bus.valid_in2;
        w_captureEven = (r_state == ST_EVEN) ||
                        ((r_state == ST_UNSYNC) && w_anyValid);
        w_captureOdd  = (r_state == ST_ODD);
        w_nextPhase   = (r_state == ST_EVEN) ? ST_ODD : ST_EVEN;
    end

    // Phase tracker, idle watchdog and alignment flag. Once locked, the
    // phase alternates every cycle whether or not data is valid, mirroring
    // the Tx mux. Alignment is announced when the first completed pair is
    // presented, and withdrawn on the edge the idle run reaches the limit.
    // A valid on that same edge takes priority and keeps the lock.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_state       <= ST_UNSYNC;
            r_idleCount   <= '0;
            r_loadPending <= 1'b0;
            r_aligned     <= 1'b0;
        end else begin
            r_loadPending <= (r_state == ST_ODD);

            if (r_loadPending && (r_state != ST_UNSYNC)) begin
                r_aligned <= 1'b1;
            end

            case (r_state)
                ST_UNSYNC: begin
                    r_idleCount <= '0;
                    if (w_anyValid) begin
                        r_state <= ST_ODD;
                    end
                end

                ST_EVEN, ST_ODD: begin
                    if (w_anyValid) begin
                        r_idleCount <= '0;
                        r_state     <= w_nextPhase;
                    end else if (r_idleCount >= IDLE_LAST) begin
                        r_idleCount <= '0;
                        r_state     <= ST_UNSYNC;
                        r_aligned   <= 1'b0;
                    end else begin
                        if (r_idleCount < IDLE_MAX) begin
                            r_idleCount <= r_idleCount + CW'(1);
                        end
                        r_state <= w_nextPhase;
                    end
                end

                default: begin
                    r_idleCount <= '0;
                    r_state     <= ST_UNSYNC;
                    r_aligned   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.aligned = r_aligned;

    // Stream 1 carries lanes 0 (even) and 1 (odd).
    demux_1to2_l1 #(
        .WIDTH(WIDTH)
    ) u_stream1 (
        .clk_2f       (clk_2f),
        .reset        (reset),
        .i_data       (bus.data_in1),
        .i_valid      (bus.valid_in1),
        .i_captureEven(w_captureEven),
        .i_captureOdd (w_captureOdd),
        .i_load       (r_loadPending),
        .o_dataEven   (bus.data_out0),
        .o_validEven  (bus.valid_out0),
        .o_dataOdd    (bus.data_out1),
        .o_validOdd   (bus.valid_out1)
    );

    // Stream 2 carries lanes 2 (even) and 3 (odd).
    demux_1to2_l1 #(
        .WIDTH(WIDTH)
    ) u_stream2 (
        .clk_2f       (clk_2f),
        .reset        (reset),
        .i_data       (bus.data_in2),
        .i_valid      (bus.valid_in2),
        .i_captureEven(w_captureEven),
        .i_captureOdd (w_captureOdd),
        .i_load       (r_loadPending),
        .o_dataEven   (bus.data_out2),
        .o_validEven  (bus.valid_out2),
        .o_dataOdd    (bus.data_out3),
        .o_validOdd   (bus.valid_out3)
    );

endmodule
